// File: rtl/kamacore_fetch_unit.sv
// rtl/kamacore_fetch_unit.sv - kamacore instruction fetch stage
// Single outstanding imem request, one-entry decode buffer, redirect flush.
module kamacore_fetch_unit #(
  parameter int                    CPU_WIDTH  = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [CPU_WIDTH-1:0]  imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [CPU_WIDTH-1:0]  inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic [ADDR_WIDTH-1:0] redirect_offset
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redirect_sum;
  logic [ADDR_WIDTH-1:0] redirect_target;

  assign redirect_sum    = redirect_pc + redirect_offset;
  assign redirect_target = {redirect_sum[ADDR_WIDTH-1:1], 1'b0};

  // Gating with rst_n keeps the request low while reset is held.
  assign imem_req_valid = rst_n && (state == ST_REQ);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else if (redirect_valid) begin
      // Any response landing this cycle belongs to the wrong path.
      pc         <= redirect_target;
      inst_valid <= 1'b0;
      case (state)
        ST_REQ:   state <= imem_req_ready ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_HOLD:  state <= ST_REQ;
        default:  state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            inst_data  <= imem_rsp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + ADDR_WIDTH'(4);
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
            state      <= ST_REQ;
          end
        end
        default: begin
          if (imem_rsp_valid) state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kamacore_fetch_unit.sv
// tb/tb_kamacore_fetch_unit.sv - self-checking bench for kamacore_fetch_unit
// Memory responder and decode-stream scoreboard live in the tick task.
module tb_kamacore_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_offset;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = RST_PC;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;
  logic [31:0] hs_q[$];
  logic [31:0] cons_q[$];
  int          cons_cyc[$];

  kamacore_fetch_unit #(.CPU_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_offset(redirect_offset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  // One clock: observe before the edge, update the memory model after it.
  task automatic tick();
    logic        hs, cons, red;
    logic [31:0] haddr, tgt;
    @(negedge clk);
    hs    = imem_req_valid && imem_req_ready;
    haddr = imem_req_addr;
    red   = redirect_valid && rst_n;
    cons  = inst_valid && inst_ready && !red && rst_n;
    tgt   = (redirect_pc + redirect_offset) & ~32'h1;
    if (stall_prev && rst_n) begin
      checks++;
      if (!imem_req_valid || imem_req_addr !== stall_addr) begin
        errors++;
        $display("FAIL req_stable: valid=%0b addr=%h required valid=1 addr=%h",
                 imem_req_valid, imem_req_addr, stall_addr);
      end
    end
    stall_prev = rst_n && imem_req_valid && !imem_req_ready && !redirect_valid;
    stall_addr = haddr;
    if (hs) begin
      checks++;
      if (pend) begin
        errors++;
        $display("FAIL one_outstanding: request %h while %h pending required none", haddr, pend_addr);
      end
      hs_q.push_back(haddr);
    end
    if (cons) begin
      checks++;
      if (inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL decode_stream: pc=%h data=%h required pc=%h data=%h",
                 inst_pc, inst_data, exp_pc, mem_word(exp_pc));
      end
      cons_q.push_back(inst_pc);
      cons_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
    if (red) exp_pc = tgt;
    if (!rst_n) exp_pc = RST_PC;
    @(posedge clk);
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (hs) begin
        pend = 1'b1; pend_cnt = lat; pend_addr = haddr;
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_logs();
    hs_q.delete(); cons_q.delete(); cons_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; redirect_offset = '0; lat = 1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; stall_prev = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic set_redirect(input logic [31:0] p, input logic [31:0] o);
    redirect_valid = 1'b1; redirect_pc = p; redirect_offset = o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; redirect_offset = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    tick(); tick();
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req_valid=%0b inst_valid=%0b data=%h pc=%h required all 0",
               imem_req_valid, inst_valid, inst_data, inst_pc);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_release: req_valid=%0b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
    clear_logs();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (hs_q.size() < 3 || hs_q[0] !== 32'h100 || hs_q[1] !== 32'h104 || hs_q[2] !== 32'h108) begin
      errors++;
      $display("FAIL stream_addrs: got %0d requests first=%h required 100,104,108",
               hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : 32'hx);
    end
    checks++;
    if (cons_cyc.size() < 3 || cons_cyc[1] - cons_cyc[0] != 3 || cons_cyc[2] - cons_cyc[1] != 3) begin
      errors++;
      $display("FAIL stream_rate: %0d deliveries required >=3 spaced 3 cycles", cons_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int n_req;
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    checks++;
    if (!inst_valid) begin
      errors++;
      $display("FAIL bp_first: inst_valid=0 required 1 within 10 cycles");
    end
    d = inst_data;
    n_req = hs_q.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_data !== d || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: valid=%0b data=%h req=%0b required 1 %h 0",
                 inst_valid, inst_data, imem_req_valid, d);
      end
    end
    inst_ready = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104 || hs_q.size() != n_req) begin
      errors++;
      $display("FAIL bp_resume: req=%0b addr=%h required 1 104", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 2;
    tick();
    set_redirect(32'h200, 32'hFFFF_FFF8);
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1F8 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait: req=%0b addr=%h inst_valid=%0b required 1 1f8 0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
    for (int i = 0; i < 12 && cons_q.size() == 0; i++) tick();
    checks++;
    if (cons_q.size() == 0 || cons_q[0] !== 32'h1F8) begin
      errors++;
      $display("FAIL redir_wait_first: first decoded pc=%h required 1f8",
               (cons_q.size() > 0) ? cons_q[0] : 32'hx);
    end
    lat = 1;
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    tick();
    set_redirect(32'h300, 32'h0);
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
      errors++;
      $display("FAIL redir_rsp: inst_valid=%0b req=%0b addr=%h required 0 1 300",
               inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    tick(); tick();
    set_redirect(32'h400, 32'h11);
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h410 || cons_q.size() != 0) begin
      errors++;
      $display("FAIL redir_hold: inst_valid=%0b req=%0b addr=%h decoded=%0d required 0 1 410 0",
               inst_valid, imem_req_valid, imem_req_addr, cons_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b0;
    set_redirect(32'hFFFF_FFF0, 32'hC);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (hs_q.size() < 2 || hs_q[0] !== 32'hFFFF_FFFC || hs_q[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap: %0d requests second=%h required fffffffc then 0",
               hs_q.size(), (hs_q.size() > 1) ? hs_q[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    lat = 3;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: inst_valid=%0b req=%0b required 0 0", inst_valid, imem_req_valid);
    end
    tick();
    rst_n = 1'b1;
    lat = 1;
    clear_logs();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_restart: req=%0b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      imem_req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready      = ($urandom_range(0, 2) != 0);
      lat             = $urandom_range(1, 3);
      redirect_valid  = ($urandom_range(0, 99) < 8);
      redirect_pc     = $urandom;
      redirect_offset = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    checks++;
    if (cons_q.size() < 20) begin
      errors++;
      $display("FAIL random_progress: %0d instructions decoded required >=20", cons_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kamacore_fetch_unit.md
Name: kamacore_fetch_unit

Overview:
- Instruction fetch stage of kamacore. Holds the PC and issues one instruction-memory request at a time.
- Returns each fetched word to decode through a single-entry valid/ready output register.
- Accepts redirects from the branching unit downstream, given as the branch PC plus the byte offset that unit computes. A redirect flushes wrong-path work and restarts fetch at the target.

Parameters:
CPU_WIDTH, 32, instruction/data word width
ADDR_WIDTH, 32, PC and memory address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_WIDTH  fetch address (= pc)
imem_rsp_valid  input  1  response word valid (1-cycle pulse per accepted request)
imem_rsp_data  input  CPU_WIDTH  fetched instruction
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst_data  output  CPU_WIDTH  instruction word
inst_pc  output  ADDR_WIDTH  address the instruction was fetched from
redirect_valid  input  1  taken branch, from branching unit branch_valid gated by execute
redirect_pc  input  ADDR_WIDTH  PC of the branch instruction
redirect_offset  input  ADDR_WIDTH  sign-extended byte offset from branching unit

Behaviour:
- Reset (async assert, sync-released use): pc=RESET_PC, state=REQ, inst_valid=0, inst_data=0, inst_pc=0. Outputs are registered or decoded from state only. imem_req_valid=1 in the first cycle after rst_n rises.
- States:
  - REQ: imem_req_valid=1, addr=pc. On imem_req_ready, go to WAIT. The output buffer is always empty in REQ.
  - WAIT: await imem_rsp_valid. On response: inst_data<=rsp_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (wraps modulo 2^ADDR_WIDTH), go to HOLD.
  - HOLD: on inst_valid&&inst_ready, clear inst_valid and go to REQ.
  - DRAIN: one stale request is outstanding. On imem_rsp_valid, discard the data (no buffer write) and go to REQ.
- Sustained throughput is 1 instruction per 3 cycles with 1-cycle memory latency and ready=1. Only one request is ever outstanding.
- imem_req_valid, once high, stays high with a stable address until accepted. The sole exception is a redirect, which may replace the address in REQ.
- Redirect (highest priority, any state):
  - Target: pc <= (redirect_pc + redirect_offset) with bit0 forced to 0; the sum truncates to ADDR_WIDTH. Bit1 is not checked; misalignment handling is downstream.
  - inst_valid <= 0 on the same edge (flush), even if inst_ready was high that cycle.
  - REQ without handshake that cycle: stay in REQ; the next cycle presents the new address.
  - REQ with handshake that cycle: the old request is in flight, so go to DRAIN.
  - WAIT without rsp_valid: go to DRAIN.
  - WAIT with rsp_valid the same cycle: discard the response and go to REQ.
  - HOLD: go to REQ.
  - DRAIN: stay in DRAIN (rsp_valid that cycle also → REQ); the pc is updated.
- Back-to-back redirects: the last one wins. Every redirect-cycle response is discarded.
- imem_rsp_valid in REQ or HOLD is a protocol error; ignore it.

Test Plan:
- Reset release, RESET_PC=0x100, memory ready=1, latency 1, inst_ready=1:
  - imem_req_addr sequence 0x100, 0x104, 0x108.
  - inst_pc/inst_data match memory.
  - One instruction per 3 cycles.
- Back-pressure: inst_ready=0 for 5 cycles after the first instruction:
  - inst_valid/inst_data held stable.
  - No new request issued.
  - The next request (0x104) issues the cycle after inst_ready rises.
- Redirect in WAIT, redirect_pc=0x200, offset=0xFFFF_FFF8:
  - The in-flight response is discarded; decode never sees it.
  - The next request address is 0x1F8.
- Redirect coincident with imem_rsp_valid in WAIT, target 0x300:
  - Response dropped, inst_valid stays 0.
  - Next cycle imem_req_addr=0x300.
- Redirect while HOLD with inst_ready=1 the same cycle:
  - inst_valid is 0 next cycle.
  - pc=target, state REQ.
  - The buffered instruction counts as flushed (decode kills it).
- Wrap: redirect to 0xFFFF_FFFC, fetch completes → next request address is 0x0000_0000. Separately, assert rst_n=0 mid-WAIT → inst_valid=0 and imem_req_valid=0 immediately, then restart at RESET_PC.
